// File: rtl/gpio_mmio.sv
`default_nettype none
// ============================================================================
// Module      : gpio_mmio
// Description : Memory-mapped switch/LED peripheral with synchronised inputs,
//               per-switch change events and a maskable interrupt.
//               Define GPIO_DEBOUNCE_EN to enable the per-bit debounce counters.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_mmio #(
    parameter int                    SW_WIDTH        = 10,
    parameter int                    LED_WIDTH       = 10,
    parameter int                    ADDR_WIDTH      = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = 16'hC000,
    parameter int                    DEBOUNCE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  re,
    input  logic                  we,
    input  logic [15:0]           wdata,
    output logic [15:0]           rdata,
    input  logic [SW_WIDTH-1:0]   sw_in,
    output logic [LED_WIDTH-1:0]  led_out,
    output logic                  irq
);

    localparam logic [1:0] REG_SW     = 2'd0;
    localparam logic [1:0] REG_LED    = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_MASK   = 2'd3;

    logic [ADDR_WIDTH-1:0] offset;
    logic                  in_range;
    logic [1:0]            reg_sel;
    logic                  wr_led;
    logic                  wr_status;
    logic                  wr_mask;
    logic [15:0]           read_val;

    logic [SW_WIDTH-1:0]   sync_meta;
    logic [SW_WIDTH-1:0]   sync_q;
    logic [SW_WIDTH-1:0]   db;
    logic [SW_WIDTH-1:0]   db_prev;
    logic [SW_WIDTH-1:0]   accept;
    logic [SW_WIDTH-1:0]   status;
    logic [SW_WIDTH-1:0]   status_clr;
    logic [SW_WIDTH-1:0]   mask;

    // Unsigned wrap makes every address below BASE_ADDR decode as out of range.
    assign offset    = addr - BASE_ADDR;
    assign in_range  = (offset < ADDR_WIDTH'(4));
    assign reg_sel   = offset[1:0];
    assign wr_led    = we && in_range && (reg_sel == REG_LED);
    assign wr_status = we && in_range && (reg_sel == REG_STATUS);
    assign wr_mask   = we && in_range && (reg_sel == REG_MASK);

    logic unused_bits;
    assign unused_bits = &{1'b0, wdata};

    always_comb begin
        read_val = '0;
        case (reg_sel)
            REG_SW:     read_val[SW_WIDTH-1:0]  = db;
            REG_LED:    read_val[LED_WIDTH-1:0] = led_out;
            REG_STATUS: read_val[SW_WIDTH-1:0]  = status;
            REG_MASK:   read_val[SW_WIDTH-1:0]  = mask;
            default:    read_val                = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta <= '0;
            sync_q    <= '0;
        end else begin
            sync_meta <= sw_in;
            sync_q    <= sync_meta;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam int            CW      = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    for (genvar i = 0; i < SW_WIDTH; i++) begin : g_debounce
        logic [CW-1:0] cnt;
        logic          differ;

        assign differ    = sync_q[i] ^ db[i];
        assign accept[i] = differ && (cnt == CNT_MAX);

        // Any sample that agrees with the accepted level restarts the count.
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt <= '0;
            end else if (!differ || (cnt == CNT_MAX)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
`else
    localparam int unused_debounce = DEBOUNCE_CYCLES;
    assign accept = '1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            db      <= '0;
            db_prev <= '0;
        end else begin
            db      <= (db & ~accept) | (sync_q & accept);
            db_prev <= db;
        end
    end

    // Event set is OR-ed after the clear so a coincident event is never lost.
    assign status_clr = wr_status ? wdata[SW_WIDTH-1:0] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            status  <= '0;
            mask    <= '0;
            led_out <= '0;
            rdata   <= '0;
        end else begin
            status <= (status & ~status_clr) | (db ^ db_prev);
            if (wr_mask) begin
                mask <= wdata[SW_WIDTH-1:0];
            end
            if (wr_led) begin
                led_out <= wdata[LED_WIDTH-1:0];
            end
            rdata <= (re && in_range) ? read_val : 16'h0000;
        end
    end

    assign irq = |(status & mask);

endmodule
`default_nettype wire

// File: tb/tb_gpio_mmio.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpio_mmio
// Description : Directed plus randomised bench for gpio_mmio, compared every
//               cycle against a window-based behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_mmio;

    localparam int          SW   = 10;
    localparam int          LW   = 10;
    localparam int          DC   = 4;
    localparam logic [15:0] BASE = 16'hC000;
`ifdef GPIO_DEBOUNCE_EN
    localparam int MD = DC;
`else
    localparam int MD = 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   addr;
    logic          re;
    logic          we;
    logic [15:0]   wdata;
    logic [15:0]   rdata;
    logic [SW-1:0] sw_in;
    logic [LW-1:0] led_out;
    logic          irq;

    int checks   = 0;
    int failures = 0;

    logic [SW-1:0] db_m   = '0;
    logic [SW-1:0] dbp_m  = '0;
    logic [SW-1:0] st_m   = '0;
    logic [SW-1:0] mask_m = '0;
    logic [LW-1:0] led_m  = '0;
    logic [15:0]   rd_m   = '0;
    logic [SW-1:0] hist[$];
    bit            hit;

    gpio_mmio #(
        .SW_WIDTH        (SW),
        .LED_WIDTH       (LW),
        .ADDR_WIDTH      (16),
        .BASE_ADDR       (BASE),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .addr    (addr),
        .re      (re),
        .we      (we),
        .wdata   (wdata),
        .rdata   (rdata),
        .sw_in   (sw_in),
        .led_out (led_out),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // A level is accepted once the synchronised input has disagreed with the
    // accepted value for MD consecutive samples; sync lags sw_in by two edges.
    task automatic model_step();
        logic [SW-1:0] nd;
        logic [SW-1:0] ev;
        int            a;
        int            off;
        bit            inr;
        bit            stable;
        a   = int'(addr);
        off = a - int'(BASE);
        inr = (off >= 0) && (off <= 3);
        if (rst) begin
            db_m = '0; dbp_m = '0; st_m = '0; mask_m = '0; led_m = '0; rd_m = '0;
            hist.delete();
            repeat (MD + 2) hist.push_back('0);
        end else begin
            rd_m = 16'h0000;
            if (re && inr) begin
                case (off)
                    0:       rd_m = 16'(db_m);
                    1:       rd_m = 16'(led_m);
                    2:       rd_m = 16'(st_m);
                    default: rd_m = 16'(mask_m);
                endcase
            end
            ev = db_m ^ dbp_m;
            nd = db_m;
            for (int b = 0; b < SW; b++) begin
                stable = 1'b1;
                for (int j = 1; j <= MD; j++)
                    if (hist[hist.size() - 1 - j][b] == db_m[b]) stable = 1'b0;
                if (stable) nd[b] = ~db_m[b];
            end
            if (we && inr && off == 2) st_m = (st_m & ~wdata[SW-1:0]) | ev;
            else                       st_m = st_m | ev;
            if (we && inr && off == 1) led_m  = wdata[LW-1:0];
            if (we && inr && off == 3) mask_m = wdata[SW-1:0];
            dbp_m = db_m;
            db_m  = nd;
            hist.push_back(sw_in);
            if (hist.size() > MD + 2) void'(hist.pop_front());
        end
    endtask

    task automatic cyc(input logic r, input logic w, input int off, input logic [15:0] d);
        @(negedge clk);
        re    = r;
        we    = w;
        addr  = BASE + 16'(off);
        wdata = d;
        @(posedge clk);
        #1;
        model_step();
        chk("rdata", rdata, rd_m);
        chk("led_out", 16'(led_out), 16'(led_m));
        chk("irq", 16'(irq), 16'(|(st_m & mask_m)));
    endtask

    initial begin
        rst = 1'b1; re = 1'b0; we = 1'b0; addr = '0; wdata = '0; sw_in = '0;

        // Reset and register read-back
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("reset_led", 16'(led_out), 16'h0000);
        chk("reset_irq", 16'(irq), 16'h0000);
        rst = 1'b0;
        for (int o = 0; o < 4; o++) begin
            cyc(1, 0, o, 0);
            chk("reset_read", rdata, 16'h0000);
        end

        // LED register
        cyc(0, 1, 1, 16'h02A5);
        chk("led_drive", 16'(led_out), 16'h02A5);
        cyc(1, 0, 1, 0);
        chk("led_read", rdata, 16'h02A5);
        cyc(0, 1, 1, 16'hFFFF);
        cyc(1, 0, 1, 0);
        chk("led_trunc", rdata, 16'h03FF);

        // Switch latency and event
        sw_in = 10'h001;
        cyc(0, 0, 0, 0);
        repeat (MD) cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("sw_early", rdata, 16'h0000);
        cyc(1, 0, 0, 0);
        chk("sw_late", rdata, 16'h0001);
        cyc(1, 0, 2, 0);
        chk("status_set", rdata, 16'h0001);
        cyc(0, 1, 2, 16'h03FF);

`ifdef GPIO_DEBOUNCE_EN
        sw_in = 10'h000;
        repeat (3) cyc(0, 0, 0, 0);
        sw_in = 10'h001;
        repeat (10) cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("glitch_sw", rdata, 16'h0001);
        cyc(1, 0, 2, 0);
        chk("glitch_status", rdata, 16'h0000);
`endif

        // Interrupt and W1C
        cyc(0, 1, 3, 16'h0003);
        sw_in = 10'h003;
        repeat (MD + 3) cyc(0, 0, 0, 0);
        chk("irq_set", 16'(irq), 16'h0001);
        cyc(0, 1, 2, 16'h0002);
        chk("irq_clear", 16'(irq), 16'h0000);
        cyc(1, 0, 2, 0);
        chk("status_clear", rdata, 16'h0000);

        // Clear racing an event on bit 0
        sw_in = 10'h002;
        hit   = 1'b0;
        for (int n = 0; n < 20 && !hit; n++) begin
            if (db_m[0] != dbp_m[0]) begin
                cyc(0, 1, 2, 16'h0001);
                hit = 1'b1;
            end else begin
                cyc(0, 0, 0, 0);
            end
        end
        chk("race_reached", 16'(hit), 16'h0001);
        cyc(1, 0, 2, 0);
        chk("race_set_wins", 16'(rdata[0]), 16'h0001);
        cyc(1, 0, 4, 0);
        chk("read_oob", rdata, 16'h0000);
        cyc(0, 1, 0, 16'hFFFF);
        cyc(1, 0, 0, 0);
        chk("sw_ro", rdata, 16'h0002);

        // Reset in the middle of a debounce
        sw_in = 10'h006;
        repeat (4) cyc(0, 0, 0, 0);
        rst = 1'b1;
        cyc(0, 0, 0, 0);
        rst = 1'b0;
        cyc(1, 0, 0, 0);
        chk("rst_mid_sw", rdata, 16'h0000);
        repeat (MD) cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("rst_redo_early", rdata, 16'h0000);
        cyc(1, 0, 0, 0);
        chk("rst_redo_late", rdata, 16'h0006);

        // Randomised traffic
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 7) == 0) sw_in = sw_in ^ SW'($urandom);
            rst = ($urandom_range(0, 149) == 0);
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 5)) - 1, 16'($urandom));
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
